// File: rtl/axis_output_arbiter_pkg.sv
// Shared router definitions: arbiter state encoding, mesh port indices and
// the saturating-increment helper used by the PMU counters.
package axis_output_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic [2:0] {
    HOME  = 3'd0,
    NORTH = 3'd1,
    EAST  = 3'd2,
    SOUTH = 3'd3,
    WEST  = 3'd4
  } port_idx_t;

  localparam int MAX_CNT_WIDTH = 64;

  // Operates on the widest counter; callers zero-extend in and truncate out.
  function automatic logic [MAX_CNT_WIDTH-1:0] sat_inc(
    input logic [MAX_CNT_WIDTH-1:0] cnt,
    input int                       width
  );
    logic [MAX_CNT_WIDTH-1:0] max_val;
    max_val = {MAX_CNT_WIDTH{1'b1}} >> (MAX_CNT_WIDTH - width);
    return (cnt == max_val) ? cnt : cnt + MAX_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/axis_output_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest
// set bit, rotate the index back. Generic so other allocators can reuse it.
module rr_pick #(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [W-1:0]   offset;
  logic [W:0]     sum;

  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[N-1:0];
    offset  = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req_rot[k]) begin
        any    = 1'b1;
        offset = W'(k);
      end
    end
    // N need not be a power of two, so wrap by compare rather than truncation.
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    idx   = sum[W-1:0];
    grant = any ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
  end

endmodule

// File: rtl/axis_output_arbiter.sv
// Packet-locking round-robin arbiter for one router output port, with
// saturating packet and stall counters for the PMU.
//   state  | meaning
//   IDLE   | no owner; pick a winner among requesters, no transfer this cycle
//   LOCKED | sel_o owns the output until its TLAST handshake
module axis_output_arbiter
  import axis_output_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS = 5,
  parameter  int CNT_WIDTH = 32,
  localparam int SEL_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] last_i,
  input  logic                 out_ready_i,
  output logic                 out_valid_o,
  output logic [NUM_PORTS-1:0] in_ready_o,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [SEL_WIDTH-1:0] sel_o,
  input  logic                 pmu_clear_i,
  output logic [CNT_WIDTH-1:0] pkt_cnt_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  arb_state_t             state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [SEL_WIDTH-1:0]   ptr_q, ptr_d;
  logic [NUM_PORTS-1:0]   pick_grant;
  logic [SEL_WIDTH-1:0]   pick_idx;
  logic                   pick_any;
  logic                   handshake;
  logic                   pkt_done;
  logic                   stall;
  logic [CNT_WIDTH-1:0]   pkt_cnt_q, stall_cnt_q;

  rr_pick #(.N(NUM_PORTS), .W(SEL_WIDTH)) u_rr_pick (
    .req   (req_i),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = LOCKED;
          grant_d = pick_grant;
          sel_d   = pick_idx;
        end
      end
      LOCKED: begin
        if (pkt_done) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (sel_q == SEL_WIDTH'(NUM_PORTS - 1)) ? '0 : sel_q + SEL_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid/ready pass straight through from the owner; grant stays registered.
  always_comb begin
    out_valid_o = 1'b0;
    in_ready_o  = '0;
    if (state_q == LOCKED) begin
      out_valid_o       = req_i[sel_q];
      in_ready_o[sel_q] = out_ready_i;
    end
  end

  assign handshake = out_valid_o & out_ready_i;
  assign pkt_done  = handshake & last_i[sel_q];
  assign stall     = (state_q == LOCKED) & out_valid_o & ~out_ready_i;
  assign grant_o   = grant_q;
  assign sel_o     = sel_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (pmu_clear_i) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pkt_done) pkt_cnt_q <= CNT_WIDTH'(sat_inc(MAX_CNT_WIDTH'(pkt_cnt_q), CNT_WIDTH));
      if (stall) stall_cnt_q <= CNT_WIDTH'(sat_inc(MAX_CNT_WIDTH'(stall_cnt_q), CNT_WIDTH));
    end
  end

  assign pkt_cnt_o   = pkt_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_axis_output_arbiter.sv
// Bench for axis_output_arbiter: packet sources per input port, a
// transaction-level ownership model, directed scenarios and a random soak.
module tb_axis_output_arbiter;
  localparam int NP  = 5;
  localparam int CW  = 32;
  localparam int CWS = 2;
  localparam longint MAX32 = 64'hFFFF_FFFF;
  localparam longint MAXS  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]  req = '0, last = '0;
  logic           out_ready = 1'b0, clear = 1'b0;
  logic           out_valid, out_valid_s;
  logic [NP-1:0]  in_ready, in_ready_s, grant, grant_s;
  logic [2:0]     sel, sel_s;
  logic [CW-1:0]  pkt_cnt, stall_cnt;
  logic [CWS-1:0] pkt_cnt_s, stall_cnt_s;

  axis_output_arbiter #(.NUM_PORTS(NP), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .last_i(last),
    .out_ready_i(out_ready), .out_valid_o(out_valid), .in_ready_o(in_ready),
    .grant_o(grant), .sel_o(sel), .pmu_clear_i(clear),
    .pkt_cnt_o(pkt_cnt), .stall_cnt_o(stall_cnt));

  // Narrow-counter twin sharing all inputs, so saturation is reachable quickly.
  axis_output_arbiter #(.NUM_PORTS(NP), .CNT_WIDTH(CWS)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .last_i(last),
    .out_ready_i(out_ready), .out_valid_o(out_valid_s), .in_ready_o(in_ready_s),
    .grant_o(grant_s), .sel_o(sel_s), .pmu_clear_i(clear),
    .pkt_cnt_o(pkt_cnt_s), .stall_cnt_o(stall_cnt_s));

  int checks = 0, errors = 0;
  int mis = 0, viol = 0, cyc = 0;
  string mis_what = "";

  // upstream packet sources
  int rem[NP];
  bit bubble[NP];
  int pq[NP][$];
  int enq_tot[NP];
  int dut_rx[NP];

  // ownership model
  int m_owner, m_ptr, m_sel;
  longint m_pkt, m_stall, m_pkt_s, m_stall_s;
  int glog[$];
  logic [NP-1:0] exp_grant, exp_ready;
  logic [2:0]    exp_sel;
  logic          exp_valid;

  task automatic clear_sources();
    for (int i = 0; i < NP; i++) begin
      rem[i] = 0; bubble[i] = 1'b0; pq[i].delete();
      enq_tot[i] = 0; dut_rx[i] = 0;
    end
    glog.delete();
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_sel = 0;
    m_pkt = 0; m_stall = 0; m_pkt_s = 0; m_stall_s = 0;
  endtask

  task automatic enqueue(input int p, input int len);
    pq[p].push_back(len);
    enq_tot[p] += len;
  endtask

  function automatic bit busy();
    for (int i = 0; i < NP; i++)
      if (rem[i] > 0 || pq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_sources();
    for (int i = 0; i < NP; i++) begin
      if (rem[i] == 0 && pq[i].size() > 0) rem[i] = pq[i].pop_front();
      req[i]  = (rem[i] > 0) && !bubble[i];
      last[i] = req[i] ? (rem[i] == 1) : 1'($urandom);
    end
  endtask

  task automatic model_predict();
    exp_grant = '0;
    exp_ready = '0;
    exp_valid = 1'b0;
    exp_sel   = 3'(m_sel);
    if (m_owner >= 0) begin
      exp_grant[m_owner] = 1'b1;
      exp_valid = req[m_owner];
      exp_ready[m_owner] = out_ready;
    end
  endtask

  task automatic model_advance();
    bit hs, done, st;
    hs = exp_valid && out_ready;
    st = exp_valid && !out_ready;
    done = 1'b0;
    if (hs) begin
      done = last[m_owner];
      rem[m_owner]--;
    end
    if (clear) begin
      m_pkt = 0; m_stall = 0; m_pkt_s = 0; m_stall_s = 0;
    end else begin
      if (done) begin
        if (m_pkt < MAX32) m_pkt++;
        if (m_pkt_s < MAXS) m_pkt_s++;
      end
      if (st) begin
        if (m_stall < MAX32) m_stall++;
        if (m_stall_s < MAXS) m_stall_s++;
      end
    end
    if (m_owner >= 0) begin
      if (done) begin
        m_ptr = (m_owner + 1) % NP;
        m_owner = -1;
      end
    end else begin
      for (int k = 0; k < NP; k++) begin
        int c;
        c = (m_ptr + k) % NP;
        if (m_owner < 0 && req[c]) begin
          m_owner = c; m_sel = c; glog.push_back(c);
        end
      end
    end
  endtask

  // One clock: drive sources, compare both DUTs with the model at negedge, advance.
  task automatic tick();
    drive_sources();
    @(negedge clk);
    model_predict();
    if (grant !== exp_grant || sel !== exp_sel || out_valid !== exp_valid ||
        in_ready !== exp_ready || pkt_cnt !== CW'(m_pkt) || stall_cnt !== CW'(m_stall) ||
        grant_s !== exp_grant || sel_s !== exp_sel || out_valid_s !== exp_valid ||
        in_ready_s !== exp_ready || pkt_cnt_s !== CWS'(m_pkt_s) || stall_cnt_s !== CWS'(m_stall_s)) begin
      if (mis_what == "")
        mis_what = $sformatf("cyc %0d grant %b/%b sel %0d/%0d valid %b/%b ready %b/%b pkt %0d/%0d stall %0d/%0d pkt_s %0d/%0d",
          cyc, grant, exp_grant, sel, exp_sel, out_valid, exp_valid, in_ready, exp_ready,
          pkt_cnt, m_pkt, stall_cnt, m_stall, pkt_cnt_s, m_pkt_s);
      mis++;
    end
    if ((in_ready & ~grant) != '0 || $countones(in_ready) > 1) viol++;
    if (out_valid === 1'b1 && out_ready && sel < NP) dut_rx[sel]++;
    model_advance();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, output bit ok);
    out_ready = 1'b1;
    clear = 1'b0;
    for (int i = 0; i < NP; i++) bubble[i] = 1'b0;
    for (int c = 0; c < budget && busy(); c++) tick();
    tick();
    tick();
    ok = !busy() && (m_owner < 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_sources();
    model_reset();
    req = '0; last = '0; out_ready = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mis_what = "";
  endtask

  task automatic test_reset();
    do_reset();
    if (grant !== 5'b0) begin errors++; $display("FAIL reset_grant: got %b want 00000", grant); end
    if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (in_ready !== 5'b0) begin errors++; $display("FAIL reset_ready: got %b want 00000", in_ready); end
    if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL reset_pkt: got %0d want 0", pkt_cnt); end
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    checks += 6;
    req = '1; out_ready = 1'b1;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_no_valid: got %b want 0", out_valid); end
    if (grant !== 5'b0) begin errors++; $display("FAIL idle_no_comb_grant: got %b want 00000", grant); end
    req = '0; out_ready = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    int m0 = mis;
    do_reset();
    enqueue(2, 3);
    out_ready = 1'b1;
    tick();
    checks += 3;
    if (grant !== 5'b00100) begin errors++; $display("FAIL single_grant: got %b want 00100", grant); end
    if (sel !== 3'd2) begin errors++; $display("FAIL single_sel: got %0d want 2", sel); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    drain(50, ok);
    enqueue(1, 1);
    enqueue(4, 1);
    drain(50, ok);
    checks += 5;
    if (!ok) begin errors++; $display("FAIL single_drain: timed out, busy=%b", busy()); end
    if (pkt_cnt !== 32'd3) begin errors++; $display("FAIL single_pkt_cnt: got %0d want 3", pkt_cnt); end
    if (dut_rx[2] !== 3) begin errors++; $display("FAIL single_flits: got %0d want 3", dut_rx[2]); end
    if (glog.size() !== 3 || glog[1] !== 4 || glog[2] !== 1)
      begin errors++; $display("FAIL single_ptr_next: got order %p want '{2,4,1}", glog); end
    if (mis !== m0) begin errors++; $display("FAIL single_lockstep: %0d cycles differ, first: %s", mis - m0, mis_what); end
  endtask

  task automatic test_contention();
    bit ok;
    int m0 = mis, v0 = viol;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NP; i++) enqueue(i, 2);
    drain(200, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL contention_drain: timed out"); end
    if (glog.size() !== 10) begin errors++; $display("FAIL contention_count: got %0d grants want 10", glog.size()); end
    else for (int k = 0; k < 10; k++) begin
      checks++;
      if (glog[k] !== k % NP) begin errors++; $display("FAIL contention_order[%0d]: got %0d want %0d", k, glog[k], k % NP); end
    end
    if (viol !== v0) begin errors++; $display("FAIL contention_ready_leak: %0d cycles with in_ready outside owner", viol - v0); end
    if (mis !== m0) begin errors++; $display("FAIL contention_lockstep: %0d cycles differ, first: %s", mis - m0, mis_what); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit pat[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int m0 = mis;
    do_reset();
    enqueue(3, 4);
    for (int k = 0; k < 8; k++) begin
      out_ready = pat[k];
      tick();
    end
    drain(20, ok);
    checks += 5;
    if (stall_cnt !== 32'd3) begin errors++; $display("FAIL bp_stall_cnt: got %0d want 3", stall_cnt); end
    if (pkt_cnt !== 32'd1) begin errors++; $display("FAIL bp_pkt_cnt: got %0d want 1", pkt_cnt); end
    if (dut_rx[3] !== 4) begin errors++; $display("FAIL bp_flits: got %0d want 4", dut_rx[3]); end
    if (!ok) begin errors++; $display("FAIL bp_drain: timed out"); end
    if (mis !== m0) begin errors++; $display("FAIL bp_lockstep: %0d cycles differ, first: %s", mis - m0, mis_what); end
  endtask

  task automatic test_bubble();
    bit ok;
    int m0 = mis;
    do_reset();
    enqueue(0, 4);
    enqueue(1, 2);
    out_ready = 1'b1;
    tick();
    tick();
    bubble[0] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      drive_sources();
      #1;
      checks += 2;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid[%0d]: got %b want 0", b, out_valid); end
      if (grant !== 5'b00001) begin errors++; $display("FAIL bubble_grant[%0d]: got %b want 00001", b, grant); end
      tick();
    end
    bubble[0] = 1'b0;
    drain(50, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL bubble_drain: timed out"); end
    if (glog.size() !== 2 || glog[0] !== 0 || glog[1] !== 1)
      begin errors++; $display("FAIL bubble_order: got %p want '{0,1}", glog); end
    if (dut_rx[0] !== 4 || dut_rx[1] !== 2)
      begin errors++; $display("FAIL bubble_flits: got %0d,%0d want 4,2", dut_rx[0], dut_rx[1]); end
    if (mis !== m0) begin errors++; $display("FAIL bubble_lockstep: %0d cycles differ, first: %s", mis - m0, mis_what); end
  endtask

  task automatic test_back_to_back();
    int m0 = mis;
    do_reset();
    enqueue(4, 1);
    enqueue(4, 1);
    out_ready = 1'b1;
    tick();
    checks++;
    if (grant !== 5'b10000) begin errors++; $display("FAIL b2b_grant1: got %b want 10000", grant); end
    tick();
    checks++;
    if (grant !== 5'b00000) begin errors++; $display("FAIL b2b_idle_gap: got %b want 00000", grant); end
    tick();
    checks++;
    if (grant !== 5'b10000) begin errors++; $display("FAIL b2b_grant2: got %b want 10000", grant); end
    tick();
    tick();
    checks += 2;
    if (pkt_cnt !== 32'd2) begin errors++; $display("FAIL b2b_pkt_cnt: got %0d want 2", pkt_cnt); end
    if (mis !== m0) begin errors++; $display("FAIL b2b_lockstep: %0d cycles differ, first: %s", mis - m0, mis_what); end
  endtask

  task automatic test_pmu();
    bit ok;
    int m0 = mis;
    do_reset();
    enqueue(1, 1);
    enqueue(2, 1);
    drain(20, ok);
    checks++;
    if (pkt_cnt_s !== 2'd2) begin errors++; $display("FAIL pmu_preload: got %0d want 2", pkt_cnt_s); end
    enqueue(3, 1);
    enqueue(4, 1);
    drain(20, ok);
    checks += 2;
    if (pkt_cnt_s !== 2'd3) begin errors++; $display("FAIL pmu_saturate: got %0d want 3", pkt_cnt_s); end
    if (pkt_cnt !== 32'd4) begin errors++; $display("FAIL pmu_wide_cnt: got %0d want 4", pkt_cnt); end
    enqueue(0, 1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks += 2;
    if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL pmu_clear_wins: got %0d want 0", pkt_cnt); end
    if (pkt_cnt_s !== 2'd0) begin errors++; $display("FAIL pmu_clear_wins_s: got %0d want 0", pkt_cnt_s); end
    tick();
    checks += 2;
    if (!ok) begin errors++; $display("FAIL pmu_drain: timed out"); end
    if (mis !== m0) begin errors++; $display("FAIL pmu_lockstep: %0d cycles differ, first: %s", mis - m0, mis_what); end
  endtask

  task automatic test_async_reset();
    bit ok;
    int m0 = mis;
    do_reset();
    enqueue(0, 1);
    out_ready = 1'b0;
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    enqueue(3, 5);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (grant !== 5'b0) begin errors++; $display("FAIL arst_grant: got %b want 00000", grant); end
    if (sel !== 3'd0) begin errors++; $display("FAIL arst_sel: got %0d want 0", sel); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", out_valid); end
    if (in_ready !== 5'b0) begin errors++; $display("FAIL arst_ready: got %b want 00000", in_ready); end
    if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL arst_pkt: got %0d want 0", pkt_cnt); end
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL arst_stall: got %0d want 0", stall_cnt); end
    clear_sources();
    model_reset();
    req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    enqueue(4, 1);
    enqueue(3, 1);
    enqueue(2, 2);
    drain(50, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL arst_drain: timed out"); end
    if (glog.size() < 1 || glog[0] !== 2) begin errors++; $display("FAIL arst_first_grant: got %p want first 2", glog); end
    if (mis !== m0) begin errors++; $display("FAIL arst_lockstep: %0d cycles differ, first: %s", mis - m0, mis_what); end
  endtask

  task automatic test_random();
    bit ok;
    int m0 = mis, v0 = viol;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int p;
        p = $urandom_range(0, NP - 1);
        if (pq[p].size() < 4) enqueue(p, $urandom_range(1, 4));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NP; i++) bubble[i] = ($urandom_range(0, 7) == 0);
      clear = ($urandom_range(0, 49) == 0);
      tick();
    end
    drain(2000, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL rand_drain: timed out"); end
    if (viol !== v0) begin errors++; $display("FAIL rand_ready_leak: %0d cycles", viol - v0); end
    if (mis !== m0) begin errors++; $display("FAIL rand_lockstep: %0d cycles differ, first: %s", mis - m0, mis_what); end
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (dut_rx[i] !== enq_tot[i]) begin errors++; $display("FAIL rand_flits[%0d]: got %0d want %0d", i, dut_rx[i], enq_tot[i]); end
    end
  endtask

  initial begin
    clear_sources();
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_bubble();
    test_back_to_back();
    test_pmu();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_output_arbiter.md
# axis_output_arbiter

Round-robin, packet-locking output-port arbiter for one output of the XY mesh router. Shares a single downstream AXI-Stream channel (HOME, NORTH, EAST, SOUTH or WEST) between the router input ports whose head flits route to that output. A grant holds from the first flit to the TLAST handshake, so packets are never interleaved. Carries two saturating event counters for the built-in PMUs. The router instantiates one per output port.

## Interface
- NUM_PORTS, 5: number of requesting input ports, index order HOME, NORTH, EAST, SOUTH, WEST.
- CNT_WIDTH, 32: width of each PMU counter.
- SEL_WIDTH, $clog2(NUM_PORTS): width of the winner index (derived, not overridden).

Ports:
- clk_i  in  1  router clock; all state is on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- req_i  in  NUM_PORTS  bit i is input i's TVALID, already qualified by the XY route decode for this output.
- last_i  in  NUM_PORTS  TLAST of input i's head flit; sampled only where req_i[i]=1.
- out_ready_i  in  1  TREADY from the downstream output channel.
- out_valid_o  out  1  TVALID toward downstream.
- in_ready_o  out  NUM_PORTS  TREADY returned to each input; at most one bit set.
- grant_o  out  NUM_PORTS  one-hot current owner, all zero when unowned; drives the router data mux.
- sel_o  out  SEL_WIDTH  binary index of the owner; holds its last value when unowned.
- pmu_clear_i  in  1  synchronous clear of both counters.
- pkt_cnt_o  out  CNT_WIDTH  count of completed packets (TLAST handshakes).
- stall_cnt_o  out  CNT_WIDTH  count of owned cycles with out_valid_o=1 and out_ready_i=0.

## Operation
- FSM states: IDLE and LOCKED. Reset state is IDLE.
- Reset values: grant_o=0, sel_o=0, out_valid_o=0, in_ready_o=0, both counters 0, round-robin pointer ptr=0.
- In IDLE, when any req_i bit is set:
  - The winner is the first requester found at ptr, ptr+1, … wrapping modulo NUM_PORTS.
  - The winner is registered into grant_o/sel_o and the FSM moves to LOCKED.
  - No transfer happens in the IDLE cycle.
- In IDLE with no requests, the FSM stays in IDLE and ptr is unchanged.
- In LOCKED, with s = sel_o:
  - out_valid_o = req_i[s].
  - in_ready_o[s] = out_ready_i; all other in_ready_o bits are 0.
  - A handshake is out_valid_o & out_ready_i.
- If req_i[s] drops mid-packet (upstream bubble), the FSM stays in LOCKED and out_valid_o=0. Wormhole ownership holds until TLAST.
- On a handshake with last_i[s]=1:
  - The FSM returns to IDLE and grant_o clears.
  - ptr becomes (s+1) mod NUM_PORTS. NUM_PORTS need not be a power of two, so the wrap uses explicit compare.
  - pkt_cnt increments.
- Requests from non-owners in LOCKED are ignored and never see in_ready_o.
- Counters saturate at all-ones. pmu_clear_i zeroes both counters and wins over a same-cycle increment.
- Reset mid-packet returns everything to reset values. The partial packet is the upstream's responsibility.

## Timing
- Arbitration latency: 1 cycle from req_i rising in IDLE to grant_o/out_valid_o.
- out_valid_o and in_ready_o are combinational from req_i, out_ready_i and registered state. There is no combinational path from req_i to grant_o.
- Throughput: in LOCKED, one flit per cycle while req_i[s] and out_ready_i are both high.
- There is one IDLE bubble cycle between consecutive packets, including back-to-back packets from the same port.
- A single-flit packet (TLAST on the first flit) is: IDLE, LOCKED for one cycle with a handshake, then IDLE.
- Counter outputs are registered and reflect events from the previous cycle.

## Structure
- Shared package (router package): arb_state_t enum {IDLE, LOCKED} and the port index constants HOME=0 … WEST=4, the same encoding the mesh uses.
- One sub-module, rr_pick: combinational rotate-priority-rotate back.
  - Inputs: req vector and ptr.
  - Outputs: one-hot winner, binary index and any.
  - Reused by later allocators.
- Counters stay inline. The saturating-increment helper function goes in the package.

## Test plan
- Single requester: req_i=00100 with 3-flit packet, out_ready_i=1. Expect grant_o=00100 and sel_o=2 one cycle later, three handshakes, return to IDLE, pkt_cnt_o=1, ptr=3.
- Full contention: all five ports request continuous 2-flit packets from reset. Expect grant order 0,1,2,3,4,0. No port ever receives in_ready_o while another is granted.
- Backpressure: owner sends 4 flits and out_ready_i is low for 3 owned cycles with out_valid_o=1. Expect stall_cnt_o=3 and no flit lost or duplicated.
- Upstream bubble: owner drops req_i for 2 cycles mid-packet while port 1 requests. Expect out_valid_o=0, grant held, and port 1 granted only after the owner's TLAST.
- PMU: preload pkt_cnt to all-ones-1, complete 2 packets, expect saturation at all-ones. Then assert pmu_clear_i on a TLAST cycle and expect 0.
- Async reset while LOCKED mid-packet: all outputs reach reset values immediately. After release, the first grant goes to the lowest-index requester (ptr=0).
